// File: rtl/tank_ctrl.sv
// tank_ctrl: player tank controller.
// Decodes two HID key slots into a facing/movement, moves the tank with
// edge clamping and a blocked qualifier, and runs the fire/cooldown FSM
// that launches a shell from the muzzle.
module tank_ctrl #(
   parameter int unsigned W         = 10,
   parameter int unsigned X_START   = 480,
   parameter int unsigned Y_START   = 240,
   parameter int unsigned X_MIN     = 1,
   parameter int unsigned X_MAX     = 639,
   parameter int unsigned Y_MIN     = 1,
   parameter int unsigned Y_MAX     = 479,
   parameter int unsigned SIZE      = 4,
   parameter int unsigned STEP      = 1,
   parameter logic [7:0]  KEY_L     = 8'd80,
   parameter logic [7:0]  KEY_R     = 8'd79,
   parameter logic [7:0]  KEY_D     = 8'd81,
   parameter logic [7:0]  KEY_U     = 8'd82,
   parameter logic [7:0]  KEY_FIRE  = 8'd44,
   parameter int unsigned COOLDOWN  = 30,
   parameter logic [1:0]  RESET_DIR = 2'b00
) (
   input  logic         frame_clk,
   input  logic         Reset,
   input  logic [7:0]   keycode0,
   input  logic [7:0]   keycode1,
   input  logic         blocked,
   input  logic         shell_busy,
   output logic [W-1:0] pos_x,
   output logic [W-1:0] pos_y,
   output logic [W-1:0] size,
   output logic [1:0]   direction,
   output logic         moving,
   output logic         fire,
   output logic [W-1:0] shell_x,
   output logic [W-1:0] shell_y,
   output logic [1:0]   shell_dir,
   output logic         cooldown_active
);

   localparam int unsigned CW = $clog2(COOLDOWN + 1);

   // Clamp limits in W+1 bits so small coordinates never wrap.
   localparam logic [W:0] LP_X_LO_LIM = (W+1)'(X_MIN + SIZE + STEP);
   localparam logic [W:0] LP_X_LO_POS = (W+1)'(X_MIN + SIZE);
   localparam logic [W:0] LP_X_HI_POS = (W+1)'(X_MAX - SIZE);
   localparam logic [W:0] LP_X_MAX    = (W+1)'(X_MAX);
   localparam logic [W:0] LP_Y_LO_LIM = (W+1)'(Y_MIN + SIZE + STEP);
   localparam logic [W:0] LP_Y_LO_POS = (W+1)'(Y_MIN + SIZE);
   localparam logic [W:0] LP_Y_HI_POS = (W+1)'(Y_MAX - SIZE);
   localparam logic [W:0] LP_Y_MAX    = (W+1)'(Y_MAX);
   localparam logic [W:0] LP_SZSTEP   = (W+1)'(SIZE + STEP);
   localparam logic [W:0] LP_STEP     = (W+1)'(STEP);

   localparam logic [W-1:0] LP_SIZE    = W'(SIZE);
   localparam logic [W-1:0] LP_MUZZLE  = W'(SIZE + 1);
   localparam logic [W-1:0] LP_X_START = W'(X_START);
   localparam logic [W-1:0] LP_Y_START = W'(Y_START);

   localparam logic [CW-1:0] LP_COOL = CW'(COOLDOWN);
   localparam logic [CW-1:0] LP_ONE  = CW'(1);

   typedef enum logic {S_READY, S_COOLDOWN} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;

   logic         w_mv0;
   logic         w_mv1;
   logic         w_mv_valid;
   logic [7:0]   w_mkey;
   logic         w_fire_req;
   logic [W:0]   w_x_ext;
   logic [W:0]   w_y_ext;
   logic [W:0]   w_nx;
   logic [W:0]   w_ny;
   logic [1:0]   w_dir;
   logic [W-1:0] w_mx;
   logic [W-1:0] w_my;

   assign size    = LP_SIZE;
   assign w_x_ext = {1'b0, pos_x};
   assign w_y_ext = {1'b0, pos_y};

   // Key decode: slot 0 wins for movement, either slot can request fire.
   always_comb begin
      w_mv0      = (keycode0 == KEY_L) || (keycode0 == KEY_R) ||
                   (keycode0 == KEY_D) || (keycode0 == KEY_U);
      w_mv1      = (keycode1 == KEY_L) || (keycode1 == KEY_R) ||
                   (keycode1 == KEY_D) || (keycode1 == KEY_U);
      w_mv_valid = w_mv0 || w_mv1;
      w_mkey     = w_mv0 ? keycode0 : keycode1;
      w_fire_req = (keycode0 == KEY_FIRE) || (keycode1 == KEY_FIRE);
   end

   // Next facing and clamped position for this edge.
   always_comb begin
      w_dir = direction;
      w_nx  = w_x_ext;
      w_ny  = w_y_ext;
      if (w_mv_valid) begin
         if (w_mkey == KEY_L)      w_dir = 2'b00;
         else if (w_mkey == KEY_R) w_dir = 2'b01;
         else if (w_mkey == KEY_D) w_dir = 2'b10;
         else                      w_dir = 2'b11;
         if (!blocked) begin
            case (w_dir)
               2'b00: w_nx = (w_x_ext < LP_X_LO_LIM) ? LP_X_LO_POS : (w_x_ext - LP_STEP);
               2'b01: w_nx = ((w_x_ext + LP_SZSTEP) > LP_X_MAX) ? LP_X_HI_POS : (w_x_ext + LP_STEP);
               2'b10: w_ny = ((w_y_ext + LP_SZSTEP) > LP_Y_MAX) ? LP_Y_HI_POS : (w_y_ext + LP_STEP);
               default: w_ny = (w_y_ext < LP_Y_LO_LIM) ? LP_Y_LO_POS : (w_y_ext - LP_STEP);
            endcase
         end
      end
   end

   // Muzzle sits SIZE+1 beyond the updated centre along the new facing.
   always_comb begin
      w_mx = w_nx[W-1:0];
      w_my = w_ny[W-1:0];
      case (w_dir)
         2'b00:   w_mx = w_nx[W-1:0] - LP_MUZZLE;
         2'b01:   w_mx = w_nx[W-1:0] + LP_MUZZLE;
         2'b10:   w_my = w_ny[W-1:0] + LP_MUZZLE;
         default: w_my = w_ny[W-1:0] - LP_MUZZLE;
      endcase
   end

   // Position, facing and fire/cooldown FSM with registered outputs.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         pos_x           <= LP_X_START;
         pos_y           <= LP_Y_START;
         direction       <= RESET_DIR;
         moving          <= 1'b0;
         fire            <= 1'b0;
         shell_x         <= '0;
         shell_y         <= '0;
         shell_dir       <= '0;
         cooldown_active <= 1'b0;
         r_state         <= S_READY;
         r_cnt           <= '0;
      end else begin
         pos_x     <= w_nx[W-1:0];
         pos_y     <= w_ny[W-1:0];
         direction <= w_dir;
         moving    <= (w_nx != w_x_ext) || (w_ny != w_y_ext);
         fire      <= 1'b0;
         case (r_state)
            S_READY: begin
               if (w_fire_req && !shell_busy) begin
                  fire            <= 1'b1;
                  shell_x         <= w_mx;
                  shell_y         <= w_my;
                  shell_dir       <= w_dir;
                  cooldown_active <= 1'b1;
                  r_state         <= S_COOLDOWN;
                  r_cnt           <= LP_COOL;
               end
            end
            S_COOLDOWN: begin
               if (r_cnt == LP_ONE) begin
                  cooldown_active <= 1'b0;
                  r_state         <= S_READY;
                  r_cnt           <= '0;
               end else begin
                  r_cnt <= r_cnt - LP_ONE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tank_ctrl.sv
// tb_tank_ctrl: directed stimulus on two tank_ctrl instances (defaults, and a
// small-X / STEP=4 / COOLDOWN=3 variant) checked every frame against a
// behavioural model, plus hand-computed literal expectations.
module tb_tank_ctrl;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic [7:0] keycode0 = '0;
   logic [7:0] keycode1 = '0;
   logic       blocked = 1'b0;
   logic       shell_busy = 1'b0;
   logic       started = 1'b0;

   logic [9:0] a_px, a_py, a_sz, a_sx, a_sy, b_px, b_py, b_sz, b_sx, b_sy;
   logic [1:0] a_dir, a_sdir, b_dir, b_sdir;
   logic       a_mov, a_fire, a_cd, b_mov, b_fire, b_cd;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 frame_clk = ~frame_clk;

   tank_ctrl u_a (
      .frame_clk(frame_clk), .Reset(Reset), .keycode0(keycode0), .keycode1(keycode1),
      .blocked(blocked), .shell_busy(shell_busy), .pos_x(a_px), .pos_y(a_py), .size(a_sz),
      .direction(a_dir), .moving(a_mov), .fire(a_fire), .shell_x(a_sx), .shell_y(a_sy),
      .shell_dir(a_sdir), .cooldown_active(a_cd));

   tank_ctrl #(.X_START(6), .STEP(4), .COOLDOWN(3)) u_b (
      .frame_clk(frame_clk), .Reset(Reset), .keycode0(keycode0), .keycode1(keycode1),
      .blocked(blocked), .shell_busy(shell_busy), .pos_x(b_px), .pos_y(b_py), .size(b_sz),
      .direction(b_dir), .moving(b_mov), .fire(b_fire), .shell_x(b_sx), .shell_y(b_sy),
      .shell_dir(b_sdir), .cooldown_active(b_cd));

   typedef struct {
      int x_start, y_start, xmin, xmax, ymin, ymax, size, step, cool;
   } cfg_t;
   typedef struct {
      int x, y, dir, moving, fire, sx, sy, sdir, since;
   } mst_t;

   cfg_t cfg[2];
   mst_t m[2];

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is_move(input int k);
      return (k == 80) || (k == 79) || (k == 81) || (k == 82);
   endfunction

   function automatic int key_dir(input int k);
      case (k)
         80: return 0;
         79: return 1;
         81: return 2;
         default: return 3;
      endcase
   endfunction

   function automatic mst_t model_reset(input cfg_t c);
      mst_t s;
      s.x = c.x_start; s.y = c.y_start; s.dir = 0; s.moving = 0; s.fire = 0;
      s.sx = 0; s.sy = 0; s.sdir = 0; s.since = 1000;
      return s;
   endfunction

   // One frame: frames since the last launch decide readiness.
   function automatic mst_t model_step(input mst_t s0, input cfg_t c, input int k0,
                                       input int k1, input bit blk, input bit busy);
      mst_t s = s0;
      int ox = s0.x;
      int oy = s0.y;
      bit mv = is_move(k0) || is_move(k1);
      int mk = is_move(k0) ? k0 : k1;
      if (mv) begin
         s.dir = key_dir(mk);
         if (!blk) begin
            case (s.dir)
               0: s.x = (s.x - c.size - c.step < c.xmin) ? c.xmin + c.size : s.x - c.step;
               1: s.x = (s.x + c.size + c.step > c.xmax) ? c.xmax - c.size : s.x + c.step;
               2: s.y = (s.y + c.size + c.step > c.ymax) ? c.ymax - c.size : s.y + c.step;
               default: s.y = (s.y - c.size - c.step < c.ymin) ? c.ymin + c.size : s.y - c.step;
            endcase
         end
      end
      s.moving = (s.x != ox) || (s.y != oy);
      if (s.since < 1000) s.since++;
      s.fire = 0;
      if ((k0 == 44 || k1 == 44) && !busy && s.since >= c.cool + 1) begin
         s.fire = 1; s.since = 0; s.sdir = s.dir; s.sx = s.x; s.sy = s.y;
         case (s.dir)
            0: s.sx = s.x - c.size - 1;
            1: s.sx = s.x + c.size + 1;
            2: s.sy = s.y + c.size + 1;
            default: s.sy = s.y - c.size - 1;
         endcase
      end
      return s;
   endfunction

   always @(posedge frame_clk or posedge Reset) begin
      for (int i = 0; i < 2; i++) begin
         if (Reset) m[i] = model_reset(cfg[i]);
         else       m[i] = model_step(m[i], cfg[i], keycode0, keycode1, blocked, shell_busy);
      end
   end

   task automatic cmp(input int i, input logic [9:0] px, input logic [9:0] py,
                      input logic [9:0] sz, input logic [1:0] dir, input logic mov,
                      input logic fr, input logic [9:0] sx, input logic [9:0] sy,
                      input logic [1:0] sdir, input logic cd);
      chk($sformatf("i%0d pos_x", i), px, m[i].x);
      chk($sformatf("i%0d pos_y", i), py, m[i].y);
      chk($sformatf("i%0d size", i), sz, cfg[i].size);
      chk($sformatf("i%0d direction", i), dir, m[i].dir);
      chk($sformatf("i%0d moving", i), mov, m[i].moving);
      chk($sformatf("i%0d fire", i), fr, m[i].fire);
      chk($sformatf("i%0d shell_x", i), sx, m[i].sx);
      chk($sformatf("i%0d shell_y", i), sy, m[i].sy);
      chk($sformatf("i%0d shell_dir", i), sdir, m[i].sdir);
      chk($sformatf("i%0d cooldown_active", i), cd, (m[i].since < cfg[i].cool) ? 1 : 0);
   endtask

   // Per-frame comparison of both instances against the model.
   always @(negedge frame_clk) begin
      if (started && !Reset) begin
         cmp(0, a_px, a_py, a_sz, a_dir, a_mov, a_fire, a_sx, a_sy, a_sdir, a_cd);
         cmp(1, b_px, b_py, b_sz, b_dir, b_mov, b_fire, b_sx, b_sy, b_sdir, b_cd);
      end
   end

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      #1;
      chk("rst pos_x", a_px, 480);
      chk("rst pos_y", a_py, 240);
      chk("rst direction", a_dir, 0);
      chk("rst fire", a_fire, 0);
      chk("rst cooldown_active", a_cd, 0);
      chk("rst shell_x", a_sx, 0);
      chk("rst b pos_x", b_px, 6);
      #1;
      Reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int nf;
      logic [7:0] tab_k0[8] = '{8'd79, 8'd82, 8'd4, 8'd81, 8'd0, 8'd80, 8'd44, 8'd81};
      logic [7:0] tab_k1[8] = '{8'd44, 8'd0, 8'd80, 8'd44, 8'd0, 8'd44, 8'd82, 8'd79};
      logic       tab_bl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       tab_bz[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

      cfg[0] = '{480, 240, 1, 639, 1, 479, 4, 1, 30};
      cfg[1] = '{6, 240, 1, 639, 1, 479, 4, 4, 3};
      do_reset();
      started = 1'b1;
      chk("size const", a_sz, 4);

      // Right held for three frames.
      keycode0 = 8'd79;
      tick(); chk("right1 x", a_px, 481); chk("right1 mov", a_mov, 1); chk("right1 dir", a_dir, 1);
      tick(); chk("right2 x", a_px, 482);
      tick(); chk("right3 x", a_px, 483); chk("right3 b x", b_px, 18);

      // Left clamp at small X with STEP=4.
      do_reset();
      keycode0 = 8'd80;
      tick(); chk("clamp x", b_px, 5); chk("clamp mov", b_mov, 1);
      tick(); chk("clamp hold x", b_px, 5); chk("clamp hold mov", b_mov, 0); chk("clamp dir", b_dir, 0);

      // Blocked: facing updates, position held.
      do_reset();
      keycode0 = 8'd82; blocked = 1'b1;
      tick(); chk("blk y", a_py, 240); chk("blk dir", a_dir, 3); chk("blk mov", a_mov, 0);
      blocked = 1'b0;
      tick(); chk("unblk y", a_py, 239); chk("unblk mov", a_mov, 1);

      // Slot priority.
      keycode0 = 8'd4; keycode1 = 8'd81;
      tick(); chk("slot1 y", a_py, 240); chk("slot1 dir", a_dir, 2);
      keycode0 = 8'd80; keycode1 = 8'd81;
      tick(); chk("slot0 x", a_px, 479); chk("slot0 y", a_py, 240);

      // Fire facing right at (480,240) and repeat spacing.
      do_reset();
      keycode0 = 8'd79; keycode1 = 8'd0; blocked = 1'b1;
      tick();
      keycode0 = 8'd0; keycode1 = 8'd44; blocked = 1'b0;
      tick();
      chk("fire pulse", a_fire, 1); chk("fire sx", a_sx, 485); chk("fire sy", a_sy, 240);
      chk("fire sdir", a_sdir, 1); chk("fire cd", a_cd, 1); chk("fire b sx", b_sx, 11);
      nf = 0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         nf += int'(a_fire);
         if (i == 29) chk("cd still active", a_cd, 1);
         if (i == 30) chk("cd released", a_cd, 0);
      end
      chk("no fire in cooldown", nf, 0);
      tick(); chk("refire after 31", a_fire, 1);

      // Reset mid-cooldown returns to READY at once.
      tick();
      do_reset();
      tick(); chk("fire after reset", a_fire, 1);

      // shell_busy inhibits fire entirely.
      do_reset();
      shell_busy = 1'b1;
      nf = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         nf += int'(a_fire) + int'(b_fire);
      end
      chk("busy no fire", nf, 0);
      shell_busy = 1'b0;
      tick(); chk("busy release fire", a_fire, 1);

      // Mixed vectors for the per-frame model.
      for (int r = 0; r < 6; r++) begin
         for (int v = 0; v < 8; v++) begin
            keycode0 = tab_k0[v]; keycode1 = tab_k1[v];
            blocked = tab_bl[v]; shell_busy = tab_bz[v];
            repeat (3) tick();
         end
      end

      @(negedge frame_clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
